// File: rtl/fp_multiplier_param_pkg.sv
// +----------------------------------------------------------------------+
// | fp_pkg : shared constants and helpers for the sequential FP multiplier|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package fp_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'd0
  } round_mode_e;

  // Only RNE exists today; the field is kept so other modes can slot in.
  localparam round_mode_e ROUND_MODE = RM_RNE;

  function automatic int bias_of(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  function automatic int word_w(input int ew, input int mw);
    return 1 + ew + mw;
  endfunction

  function automatic int iter_n(input int mw, input int rb);
    return (mw + rb) / rb;
  endfunction

  function automatic int s_finish(input int n);
    return n + 1;
  endfunction

  localparam int W         = word_w(8, 23);
  localparam int N         = iter_n(23, 1);
  localparam int S_CAPTURE = 0;
  localparam int S_FINISH  = s_finish(N);

endpackage

`default_nettype wire

// File: rtl/fp_multiplier_param_if.sv
// +----------------------------------------------------------------------+
// | fp_mul_if : run/stall handshake and operand/result bus               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface fp_mul_if #(
  parameter int EW = 8,
  parameter int MW = 23
);
  logic [EW+MW:0] x;
  logic [EW+MW:0] y;
  logic [EW+MW:0] z;
  logic           run;
  logic           stall;
  logic           ovf;
  logic           unf;

  modport master (output run, x, y, input stall, z, ovf, unf);
  modport slave  (input run, x, y, output stall, z, ovf, unf);
endinterface

`default_nettype wire

// File: rtl/fp_multiplier_param_step.sv
// +----------------------------------------------------------------------+
// | fp_mul_step : one radix-2^RB add-and-shift step of the multiplier     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fp_mul_step
  import fp_pkg::*;
#(
  parameter int M  = 24,
  parameter int RB = 1
) (
  input  logic [M-1:0]  acc_i,
  input  logic [RB-1:0] bits_i,
  input  logic [M-1:0]  mcand_i,
  output logic [M-1:0]  acc_o,
  output logic [RB-1:0] shout_o
);
  logic [M+RB-1:0] w_sum;

  // acc < 2^M and mcand*bits < 2^M*(2^RB-1), so the sum fits M+RB bits.
  assign w_sum   = (M+RB)'(acc_i) + (M+RB)'(mcand_i) * (M+RB)'(bits_i);
  assign acc_o   = w_sum[M+RB-1:RB];
  assign shout_o = w_sum[RB-1:0];
endmodule

`default_nettype wire

// File: rtl/fp_multiplier_param.sv
// +----------------------------------------------------------------------+
// | fp_multiplier_param : sequential shift-add FP multiplier with RNE     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module fp_multiplier_param
  import fp_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int RB = 1
) (
  input  logic      clk,
  input  logic      rst,
  fp_mul_if.slave   bus
);
  localparam int WORD_W = word_w(EW, MW);
  localparam int N_IT   = iter_n(MW, RB);
  localparam int M      = MW + 1;
  localparam int NB     = N_IT * RB;
  localparam int SW     = $clog2(N_IT + 2);
  localparam int BIAS_V = bias_of(EW);
  localparam logic [SW-1:0] S_CAP = SW'(S_CAPTURE);
  localparam logic [SW-1:0] S_LAST = SW'(s_finish(N_IT) - 1);
  localparam logic [EW+1:0] E_MAX = (EW+2)'((1 << EW) - 1);

  logic [SW-1:0]     s_q, s_d;
  logic              done_q, done_d;
  logic [EW:0]       xse_q, xse_d, yse_q, yse_d;
  logic [M-1:0]      mcand_q, mcand_d, acc_q, acc_d;
  logic [NB-1:0]     mplr_q, mplr_d, lo_q, lo_d;
  logic [WORD_W-1:0] z_q, z_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic [M-1:0]      step_acc;
  logic [RB-1:0]     step_out;

  fp_mul_step #(.M(M), .RB(RB)) u_step (
    .acc_i   (acc_q),
    .bits_i  (mplr_q[RB-1:0]),
    .mcand_i (mcand_q),
    .acc_o   (step_acc),
    .shout_o (step_out)
  );

  logic [2*M-1:0]    prod, pn;
  logic [M-1:0]      mant;
  logic [M:0]        mr;
  logic [MW-1:0]     frac;
  logic [EW+1:0]     e;
  logic              norm, guard, sticky, inc, rc, sign, zero_in;
  logic [WORD_W-1:0] z_fin;
  logic              ovf_fin, unf_fin;

  always_comb begin
    prod    = (2*M)'({acc_q, lo_q});
    norm    = prod[2*M-1];
    pn      = norm ? prod : (prod << 1);
    mant    = pn[2*M-1:M];
    guard   = pn[M-1];
    sticky  = |pn[M-2:0];
    inc     = (ROUND_MODE == RM_RNE) & guard & (sticky | mant[0]);
    mr      = {1'b0, mant} + (M+1)'(inc);
    rc      = mr[M];
    frac    = rc ? mr[M-1:1] : mr[MW-1:0];
    // Modular EW+2-bit arithmetic; the top bit then reads as the sign.
    e       = (EW+2)'(xse_q[EW-1:0]) + (EW+2)'(yse_q[EW-1:0])
            - (EW+2)'(BIAS_V) + (EW+2)'(norm) + (EW+2)'(rc);
    sign    = xse_q[EW] ^ yse_q[EW];
    zero_in = (xse_q[EW-1:0] == '0) | (yse_q[EW-1:0] == '0);
    z_fin   = {sign, {(WORD_W-1){1'b0}}};
    ovf_fin = 1'b0;
    unf_fin = 1'b0;
    if (zero_in) begin
      z_fin = {sign, {(WORD_W-1){1'b0}}};
    end else if (!e[EW+1] && (e >= E_MAX)) begin
      z_fin   = {sign, {EW{1'b1}}, {MW{1'b0}}};
      ovf_fin = 1'b1;
    end else if (e[EW+1] || (e == '0)) begin
      unf_fin = 1'b1;
    end else begin
      z_fin = {sign, e[EW-1:0], frac};
    end
  end

  always_comb begin
    s_d     = s_q;
    done_d  = done_q;
    xse_d   = xse_q;
    yse_d   = yse_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    lo_d    = lo_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!bus.run) begin
      s_d    = S_CAP;
      done_d = 1'b0;
    end else if (done_q) begin
      s_d = s_q;
    end else if (s_q == S_CAP) begin
      xse_d   = bus.x[WORD_W-1:MW];
      yse_d   = bus.y[WORD_W-1:MW];
      mcand_d = {1'b1, bus.x[MW-1:0]};
      mplr_d  = NB'({1'b1, bus.y[MW-1:0]});
      acc_d   = '0;
      lo_d    = '0;
      s_d     = s_q + SW'(1);
    end else if (s_q <= S_LAST) begin
      acc_d  = step_acc;
      lo_d   = NB'({step_out, lo_q} >> RB);
      mplr_d = mplr_q >> RB;
      s_d    = s_q + SW'(1);
    end else begin
      z_d    = z_fin;
      ovf_d  = ovf_fin;
      unf_d  = unf_fin;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= S_CAP;
      done_q  <= 1'b0;
      xse_q   <= '0;
      yse_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      lo_q    <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      done_q  <= done_d;
      xse_q   <= xse_d;
      yse_q   <= yse_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      lo_q    <= lo_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.stall = bus.run & ~done_q;
  assign bus.z     = z_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
endmodule

`default_nettype wire
